// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states,
// frame field widths, the word-address step and small state helpers.
package instr_mem_loader_pkg;

   localparam int BYTE_W = 8;    // stream byte
   localparam int WORD_W = 16;   // instruction word (two bytes, high first)
   localparam int ADDR_W = 16;   // instruction-memory byte address
   localparam int HDR_W  = 16;   // COUNT_HI:COUNT_LO header field

   // Consecutive instruction words are two bytes apart.
   localparam logic [ADDR_W-1:0] ADDR_STEP = 16'd2;

   typedef enum logic [3:0] {
      ST_HOLD   = 4'd0,
      ST_CNT_HI = 4'd1,
      ST_CNT_LO = 4'd2,
      ST_DAT_HI = 4'd3,
      ST_DAT_LO = 4'd4,
      ST_WRITE  = 4'd5,
      ST_CHK    = 4'd6,
      ST_RUN    = 4'd7,
      ST_ERR    = 4'd8
   } state_t;

   // States in which a stream byte may be accepted.
   function automatic logic st_accepts(input state_t s);
      case (s)
         ST_CNT_HI, ST_CNT_LO, ST_DAT_HI, ST_DAT_LO, ST_CHK: st_accepts = 1'b1;
         default:                                            st_accepts = 1'b0;
      endcase
   endfunction

   // States that belong to an in-progress frame.
   function automatic logic st_busy(input state_t s);
      case (s)
         ST_CNT_HI, ST_CNT_LO, ST_DAT_HI, ST_DAT_LO,
         ST_WRITE, ST_CHK:   st_busy = 1'b1;
         default:            st_busy = 1'b0;
      endcase
   endfunction

   // Running XOR checksum over frame bytes.
   function automatic logic [BYTE_W-1:0] chk_fold(input logic [BYTE_W-1:0] acc,
                                                  input logic [BYTE_W-1:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: receives a framed byte stream, writes 16-bit
// words to consecutive addresses and releases the CPU only after a load
// whose checksum matches.
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int          MAX_WORDS = 256,
   parameter int          CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 load_req,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 mem_we,
   output logic [15:0]          mem_addr,
   output logic [15:0]          mem_wdata,
   output logic                 cpu_hold,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [CNT_WIDTH-1:0] word_cnt
);

   localparam logic [31:0]          MAX_W32 = 32'(MAX_WORDS);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1'b1);

   state_t                state_r, state_s;
   logic [BYTE_W-1:0]     hi_r, hi_s;          // count high byte / word high byte
   logic [CNT_WIDTH-1:0]  count_r, count_s;    // words announced by the header
   logic [BYTE_W-1:0]     acc_r, acc_s;        // checksum accumulator
   logic [CNT_WIDTH-1:0]  cnt_r, cnt_s;        // words written so far
   logic [ADDR_W-1:0]     addr_r, addr_s;
   logic [WORD_W-1:0]     wdata_r, wdata_s;
   logic                  armed_r;             // low for the first edge after reset
   logic                  in_ready_r, mem_we_r, cpu_hold_r, busy_r, done_r, error_r;

   logic                  xfer_s;
   logic                  req_s;
   logic [HDR_W-1:0]      hdr_s;
   logic [CNT_WIDTH-1:0]  cnt_inc_s;

   assign in_ready  = in_ready_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = addr_r;
   assign mem_wdata = wdata_r;
   assign cpu_hold  = cpu_hold_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign error     = error_r;
   assign word_cnt  = cnt_r;

   // Next-state and datapath decode; every value defaults to a hold.
   always_comb begin
      state_s   = state_r;
      hi_s      = hi_r;
      count_s   = count_r;
      acc_s     = acc_r;
      cnt_s     = cnt_r;
      addr_s    = addr_r;
      wdata_s   = wdata_r;
      xfer_s    = in_valid & in_ready_r;
      req_s     = load_req & armed_r;
      hdr_s     = {hi_r, in_data};
      cnt_inc_s = cnt_r + CNT_ONE;

      case (state_r)
         ST_HOLD, ST_RUN, ST_ERR: begin
            if (req_s) begin
               state_s = ST_CNT_HI;
               cnt_s   = '0;
               acc_s   = 8'h00;
               addr_s  = BASE_ADDR;
            end else begin
               state_s = state_r;
            end
         end
         ST_CNT_HI: begin
            if (xfer_s) begin
               hi_s    = in_data;
               acc_s   = chk_fold(acc_r, in_data);
               state_s = ST_CNT_LO;
            end else begin
               state_s = ST_CNT_HI;
            end
         end
         ST_CNT_LO: begin
            if (xfer_s) begin
               count_s = CNT_WIDTH'(hdr_s);
               acc_s   = chk_fold(acc_r, in_data);
               if ({16'h0000, hdr_s} > MAX_W32) begin
                  state_s = ST_ERR;
               end else if (hdr_s == 16'h0000) begin
                  state_s = ST_CHK;
               end else begin
                  state_s = ST_DAT_HI;
               end
            end else begin
               state_s = ST_CNT_LO;
            end
         end
         ST_DAT_HI: begin
            if (xfer_s) begin
               hi_s    = in_data;
               acc_s   = chk_fold(acc_r, in_data);
               state_s = ST_DAT_LO;
            end else begin
               state_s = ST_DAT_HI;
            end
         end
         ST_DAT_LO: begin
            if (xfer_s) begin
               wdata_s = {hi_r, in_data};
               acc_s   = chk_fold(acc_r, in_data);
               state_s = ST_WRITE;
            end else begin
               state_s = ST_DAT_LO;
            end
         end
         ST_WRITE: begin
            // addr_r already holds BASE_ADDR + 2*cnt_r for this write.
            cnt_s  = cnt_inc_s;
            addr_s = addr_r + ADDR_STEP;
            if (cnt_inc_s == count_r) begin
               state_s = ST_CHK;
            end else begin
               state_s = ST_DAT_HI;
            end
         end
         ST_CHK: begin
            if (xfer_s) begin
               if (in_data == acc_r) begin
                  state_s = ST_RUN;
               end else begin
                  state_s = ST_ERR;
               end
            end else begin
               state_s = ST_CHK;
            end
         end
         default: begin
            state_s = ST_HOLD;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= ST_HOLD;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath registers: byte latch, header count, checksum, counter, address, data.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hi_r    <= 8'h00;
         count_r <= '0;
         acc_r   <= 8'h00;
         cnt_r   <= '0;
         addr_r  <= BASE_ADDR;
         wdata_r <= 16'h0000;
         armed_r <= 1'b0;
      end else begin
         hi_r    <= hi_s;
         count_r <= count_s;
         acc_r   <= acc_s;
         cnt_r   <= cnt_s;
         addr_r  <= addr_s;
         wdata_r <= wdata_s;
         armed_r <= 1'b1;
      end
   end

   // Status outputs registered from the next state so they align with it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         in_ready_r <= 1'b0;
         mem_we_r   <= 1'b0;
         cpu_hold_r <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
      end else begin
         in_ready_r <= st_accepts(state_s);
         mem_we_r   <= (state_s == ST_WRITE);
         cpu_hold_r <= (state_s != ST_RUN);
         busy_r     <= st_busy(state_s);
         done_r     <= (state_s == ST_RUN);
         error_r    <= (state_s == ST_ERR);
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: table of directed frames,
// randomized frames against a frame-level reference model, and hand
// sequences for reload, reset during a load and reset release.
module tb_instr_mem_loader;

   localparam int          MAXW = 256;
   localparam logic [15:0] BASE = 16'h0000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        load_req = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready, mem_we, cpu_hold, busy, done, error;
   logic [15:0] mem_addr, mem_wdata, word_cnt;

   instr_mem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .CNT_WIDTH(16)) dut (
      .clock(clock), .reset(reset), .load_req(load_req),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
      .word_cnt(word_cnt)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   int          excl_viol = 0;
   logic [31:0] wr_q[$];      // observed writes {addr, data}
   logic [31:0] exp_q[$];     // expected writes from the model
   logic [7:0]  frame_q[$];   // bytes of the frame under test
   logic        exp_done, exp_err;
   logic [15:0] exp_wc;

   typedef struct {
      logic [63:0] bytes;   // first frame byte in [63:56]
      int          len;
      logic        done;
      logic        err;
      logic [15:0] wc;
      int          nwr;
   } vec_t;
   vec_t vecs[6];

   // Write monitor and done/error exclusivity watch.
   always @(negedge clock) begin
      if (mem_we) wr_q.push_back({mem_addr, mem_wdata});
      if (done && error) excl_viol++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: expected writes and outcome straight from the frame rules.
   task automatic model();
      logic [15:0] cnt;
      logic [7:0]  x;
      exp_q.delete();
      cnt = {frame_q[0], frame_q[1]};
      if (int'(cnt) > MAXW) begin
         exp_done = 1'b0; exp_err = 1'b1; exp_wc = 16'd0;
      end else begin
         for (int i = 0; i < int'(cnt); i++)
            exp_q.push_back({16'(int'(BASE) + 2 * i), frame_q[2 + 2 * i], frame_q[3 + 2 * i]});
         x = 8'h00;
         for (int k = 0; k < frame_q.size() - 1; k++) x = x ^ frame_q[k];
         exp_done = (x == frame_q[frame_q.size() - 1]);
         exp_err  = !exp_done;
         exp_wc   = cnt;
      end
   endtask

   task automatic make_frame(input logic [15:0] cnt, input bit corrupt);
      logic [7:0] x, b;
      frame_q.delete();
      frame_q.push_back(cnt[15:8]);
      frame_q.push_back(cnt[7:0]);
      if (int'(cnt) <= MAXW) begin
         x = cnt[15:8] ^ cnt[7:0];
         for (int i = 0; i < 2 * int'(cnt); i++) begin
            b = 8'($urandom);
            frame_q.push_back(b);
            x = x ^ b;
         end
         if (corrupt) x = x ^ 8'($urandom_range(255, 1));
         frame_q.push_back(x);
      end
   endtask

   task automatic pulse_load();
      @(posedge clock); #1 load_req = 1'b1;
      @(posedge clock); #1 load_req = 1'b0;
   endtask

   // Offer one byte after 'gap' idle cycles; returns 1 ns after the transfer edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit got;
      got = 1'b0;
      repeat (gap) @(posedge clock);
      #1 in_data = b; in_valid = 1'b1;
      for (int t = 0; t < 40 && !got; t++) begin
         @(negedge clock);
         if (in_ready) begin
            @(posedge clock);
            got = 1'b1;
         end
      end
      #1 in_valid = 1'b0;
      check("byte_accepted", 32'(got), 32'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_mem_we"},   32'(mem_we),   32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'(BASE));
      check({tag, "_mem_wdata"},32'(mem_wdata),32'd0);
      check({tag, "_busy"},     32'(busy),     32'd0);
      check({tag, "_done"},     32'(done),     32'd0);
      check({tag, "_error"},    32'(error),    32'd0);
      check({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
   endtask

   // Load frame_q with random gaps and compare against the model.
   task automatic run_frame(input string tag, input int max_gap);
      int n;
      wr_q.delete();
      model();
      pulse_load();
      foreach (frame_q[i]) send_byte(frame_q[i], $urandom_range(max_gap, 0));
      // Outcome must be visible right after the last accepted byte.
      check({tag, "_done"},     32'(done),     32'(exp_done));
      check({tag, "_error"},    32'(error),    32'(exp_err));
      check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
      check({tag, "_busy"},     32'(busy),     32'd0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_word_cnt"}, 32'(word_cnt), 32'(exp_wc));
      repeat (2) @(posedge clock);
      check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp_q.size()));
      n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_write%0d", tag, i), wr_q[i], exp_q[i]);
   endtask

   initial begin
      vecs[0] = '{64'h0002_1234_5678_0A00, 7, 1'b1, 1'b0, 16'd2, 2};  // good
      vecs[1] = '{64'h0002_1234_5678_0B00, 7, 1'b0, 1'b1, 16'd2, 2};  // bad checksum
      vecs[2] = '{64'h0001_ABCD_6700_0000, 5, 1'b1, 1'b0, 16'd1, 1};  // recovers to RUN
      vecs[3] = '{64'h0000_0000_0000_0000, 3, 1'b1, 1'b0, 16'd0, 0};  // empty
      vecs[4] = '{64'h0101_0000_0000_0000, 2, 1'b0, 1'b1, 16'd0, 0};  // oversize 257
      vecs[5] = '{64'h0000_FF00_0000_0000, 3, 1'b0, 1'b1, 16'd0, 0};  // empty, bad chk

      // Reset state while reset is held.
      #12;
      check_reset_vals("reset");

      // Release reset together with a load_req: the request must be ignored.
      @(negedge clock);
      reset = 1'b1; load_req = 1'b1;
      @(posedge clock); #1 load_req = 1'b0;
      @(negedge clock);
      check("release_busy",     32'(busy),     32'd0);
      check("release_in_ready", 32'(in_ready), 32'd0);
      check("release_cpu_hold", 32'(cpu_hold), 32'd1);

      // Directed frame table.
      for (int v = 0; v < 6; v++) begin
         frame_q.delete();
         for (int k = 0; k < vecs[v].len; k++)
            frame_q.push_back(vecs[v].bytes[63 - 8 * k -: 8]);
         run_frame($sformatf("vec%0d", v), 0);
         check($sformatf("vec%0d_tbl_done", v), 32'(done),        32'(vecs[v].done));
         check($sformatf("vec%0d_tbl_err", v),  32'(error),       32'(vecs[v].err));
         check($sformatf("vec%0d_tbl_wc", v),   32'(word_cnt),    32'(vecs[v].wc));
         check($sformatf("vec%0d_tbl_nwr", v),  32'(wr_q.size()), 32'(vecs[v].nwr));
      end

      // Reload from RUN: hold and done react on the very next cycle.
      frame_q.delete();
      make_frame(16'd2, 1'b0);
      run_frame("pre_reload", 0);
      wr_q.delete();
      pulse_load();
      check("reload_cpu_hold", 32'(cpu_hold), 32'd1);
      check("reload_done",     32'(done),     32'd0);
      check("reload_busy",     32'(busy),     32'd1);
      check("reload_in_ready", 32'(in_ready), 32'd1);
      send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'hAB, 0);
      send_byte(8'hCD, 0); send_byte(8'h67, 0);
      check("reload_run_done", 32'(done), 32'd1);
      check("reload_nwrites",  32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) check("reload_write", wr_q[0], 32'h0000_ABCD);

      // Randomized frames with backpressure gaps.
      for (int r = 0; r < 24; r++) begin
         if (r % 8 == 7) make_frame(16'($urandom_range(65535, MAXW + 1)), 1'b0);
         else            make_frame(16'($urandom_range(6, 0)), ($urandom_range(3, 0) == 0));
         run_frame($sformatf("rnd%0d", r), 5);
      end

      // Largest accepted frame.
      make_frame(16'(MAXW), 1'b0);
      run_frame("max_words", 0);

      // Reset in the middle of a load, right after the first write.
      wr_q.delete();
      pulse_load();
      send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
      begin
         bit seen;
         seen = 1'b0;
         for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clock);
            seen = mem_we;
         end
         check("midload_first_write", 32'(seen), 32'd1);
      end
      #1 reset = 1'b0;
      #1 check_reset_vals("midload_reset");
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 in_data = 8'h56; in_valid = 1'b1;
      wr_q.delete();
      repeat (5) @(posedge clock);
      @(negedge clock);
      check("after_reset_in_ready", 32'(in_ready),    32'd0);
      check("after_reset_busy",     32'(busy),        32'd0);
      check("after_reset_nwrites",  32'(wr_q.size()), 32'd0);
      check("after_reset_word_cnt", 32'(word_cnt),    32'd0);
      #1 in_valid = 1'b0;

      // Loader still works after that.
      make_frame(16'd3, 1'b0);
      run_frame("post_reset", 3);

      check("done_error_exclusive", 32'(excl_viol), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writer side of the instruction-memory interface. The CPU only reads instruction memory; this block fills it.
- Accepts a framed byte stream over a valid/ready handshake.
- Assembles 16-bit instruction words and writes them to instruction memory at consecutive word addresses (step 2).
- Holds the CPU in reset until a load completes with a good checksum, then releases it.

Parameters:
BASE_ADDR, 16'h0000, byte address of the first instruction word written
MAX_WORDS, 256, largest word count accepted in a frame header
CNT_WIDTH, 16, width of the word counter and header count field

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
load_req  in  1  one-cycle request to start or restart a load; honoured only in HOLD, RUN, ERR
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader can accept a byte; a transfer occurs when in_valid and in_ready are both 1 on a rising edge
mem_we  out  1  instruction-memory write strobe, one cycle per word
mem_addr  out  16  write byte address
mem_wdata  out  16  write instruction word
cpu_hold  out  1  drives the CPU's active-high reset; 1 = CPU held
busy  out  1  1 while a frame is being received
done  out  1  1 in RUN (last load succeeded)
error  out  1  1 in ERR (last load failed)
word_cnt  out  CNT_WIDTH  words written in the current or last load

Behaviour:
- Frame format: COUNT_HI, COUNT_LO, then 2*COUNT payload bytes (each word high byte first), then CHK. CHK is the XOR of all preceding frame bytes.
- While reset=0, all outputs take their reset values asynchronously: state HOLD, cpu_hold=1, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, error=0, word_cnt=0, checksum accumulator=0.
- All outputs are registered. in_ready=1 exactly in states CNT_HI, CNT_LO, DAT_HI, DAT_LO, CHK.
- State transitions:
  - HOLD: cpu_hold=1. On load_req go to CNT_HI; clear word_cnt and the accumulator; set mem_addr=BASE_ADDR.
  - CNT_HI: on transfer, latch count[15:8]; go to CNT_LO.
  - CNT_LO: on transfer, latch count[7:0].
    - count > MAX_WORDS: go to ERR (no further bytes accepted).
    - count == 0: go to CHK.
    - otherwise: go to DAT_HI.
  - DAT_HI: on transfer, latch high byte; go to DAT_LO.
  - DAT_LO: on transfer, go to WRITE.
  - WRITE: one cycle. mem_we=1, mem_wdata={hi,lo}, mem_addr=BASE_ADDR+2*word_cnt (value before increment). On leaving, word_cnt increments; if word_cnt == count, go to CHK, else DAT_HI.
  - CHK: on transfer, compare in_data with the accumulator. Equal: go to RUN. Not equal: go to ERR.
  - RUN: cpu_hold=0, done=1. On load_req go to CNT_HI with cpu_hold=1 and done=0 on the next cycle.
  - ERR: cpu_hold=1, error=1. On load_req go to CNT_HI and clear error.
- Every accepted byte except CHK is XORed into the accumulator.
- Words already written before a checksum failure stay in memory; the CPU stays held.
- Throughput: at most one word per 3 cycles.
- in_valid gaps of any length are allowed; state is held while in_valid=0.
- load_req in any busy state (CNT_HI..CHK) is ignored. A load_req coincident with reset deassertion is ignored.
- busy=1 in CNT_HI through CHK. done and error are never both 1.
- mem_addr wraps modulo 2^16. The address arithmetic is 16-bit, with no carry out.

Decomposition:
- Shared package: FSM state enumeration (HOLD, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, CHK, RUN, ERR), the word-address step constant 2, and the frame field definitions.
- No sub-module required. The checksum accumulator and byte-pair assembler stay inline in the FSM block.

Test Plan:
- Good frame: load_req, then bytes 00 02 12 34 56 78 0A -> writes (0x0000, 0x1234) and (0x0002, 0x5678), one mem_we cycle each. Then done=1, cpu_hold=0, word_cnt=2, error=0.
- Bad checksum: same frame with CHK=0B -> both writes occur, then error=1, cpu_hold=1, done=0. A subsequent good frame returns to RUN.
- Empty and oversize frames:
  - bytes 00 00 00 -> no mem_we, done=1, word_cnt=0.
  - bytes 01 01 -> error=1 right after the second byte, in_ready=0.
- Backpressure: good frame with in_valid deasserted for 0-5 random cycles between bytes -> identical writes and final state. No byte is lost or duplicated.
- Reset mid-load: assert reset low after the first WRITE -> all outputs at reset values immediately. After release the block waits in HOLD and ignores stream bytes (in_ready=0).
- Reload: in RUN, pulse load_req -> cpu_hold=1 and done=0 next cycle. A 1-word frame 00 01 AB CD 67 writes (0x0000, 0xABCD) and returns to RUN.
